s2b_cnt_uni: RTL and testbench

- Unipolar stochastic-to-binary decoder: counts 1s in an incoming stochastic bitstream over a fixed window of 2^DATAWD cycles.
- Presents the count as a DATAWD-bit binary value with a one-cycle valid pulse.
- Sits at the output of the stochastic compute units (multipliers, adders); returns results to the binary domain at the same precision the encoders use.

---
 rtl/s2b_pkg.sv | 13 +
 rtl/s2b_win_cnt.sv | 31 +++
 rtl/s2b_cnt_uni.sv | 73 +++++++
 tb/tb_s2b_cnt_uni.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/s2b_pkg.sv
// Shared definitions for the stochastic-to-binary decoder: default width,
// FSM state encoding and the last window index.
package s2b_pkg;

    localparam int DATAWD_DEF = 8;
    localparam int WIN_LAST   = (1 << DATAWD_DEF) - 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

endpackage

// File: rtl/s2b_win_cnt.sv
// Window counter: counts sampled cycles of a 2^W window and flags the
// final cycle. Wraps to zero naturally when the window completes.
module s2b_win_cnt #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [W-1:0] LAST_IDX = '1;

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/s2b_cnt_uni.sv
// Unipolar stochastic-to-binary decoder: counts ones over a window of
// 2^DATAWD samples and presents the saturated count with a valid pulse.
module s2b_cnt_uni
    import s2b_pkg::*;
#(
    parameter int DATAWD = DATAWD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iStart,
    input  logic              iClr,
    input  logic              iBit,
    output logic              oBusy,
    output logic              oValid,
    output logic [DATAWD-1:0] oData,
    output logic              oSat
);

    state_t          state;
    logic [DATAWD:0] acc;
    logic [DATAWD:0] sum;
    logic            win_last;

    // Counter is held at zero whenever idle, so a start always begins at sample 0.
    s2b_win_cnt #(.W(DATAWD)) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (iClr || (state == S_IDLE)),
        .en   (state == S_RUN),
        .last (win_last)
    );

    // Includes the current sample so the final cycle's bit is counted.
    assign sum   = acc + {{DATAWD{1'b0}}, iBit};
    assign oBusy = (state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            oData  <= '0;
            oSat   <= 1'b0;
            oValid <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (iClr) begin
                state <= S_IDLE;
                acc   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        acc <= '0;
                        if (iStart) state <= S_RUN;
                    end
                    S_RUN: begin
                        if (win_last) begin
                            // A full window of ones overflows DATAWD bits; clip and flag it.
                            oData  <= sum[DATAWD] ? {DATAWD{1'b1}} : sum[DATAWD-1:0];
                            oSat   <= sum[DATAWD];
                            oValid <= 1'b1;
                            acc    <= '0;
                            state  <= iStart ? S_RUN : S_IDLE;
                        end else begin
                            acc <= sum;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_s2b_cnt_uni.sv
// Directed bench for s2b_cnt_uni: fixed bit patterns with hand-computed
// counts, back-to-back windows, abort and asynchronous reset.
module tb_s2b_cnt_uni;
    import s2b_pkg::*;

    localparam int WIN = WIN_LAST + 1;

    localparam int M_ZERO = 0;
    localparam int M_ONES = 1;
    localparam int M_ALT  = 2;
    localparam int M_P3   = 3;
    localparam int M_64   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       iStart;
    logic       iClr;
    logic       iBit;
    logic       oBusy;
    logic       oValid;
    logic [7:0] oData;
    logic       oSat;

    int n_pass = 0;
    int n_total = 0;

    s2b_cnt_uni #(.DATAWD(DATAWD_DEF)) dut (
        .clk    (clk),
        .rst    (rst),
        .iStart (iStart),
        .iClr   (iClr),
        .iBit   (iBit),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oData  (oData),
        .oSat   (oSat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic bit_of(input int mode, input int i);
        case (mode)
            M_ONES:  return 1'b1;
            M_ALT:   return (i % 2) == 0;
            M_P3:    return (i % 8) < 3;
            M_64:    return i < 64;
            default: return 1'b0;
        endcase
    endfunction

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    // Drives one full window; reports where oValid appeared and whether
    // oBusy stayed as expected throughout.
    task automatic run_window(input int mode, input bit hold_start,
                              output int vcnt, output int vpos, output int busy_bad);
        vcnt = 0;
        vpos = -1;
        busy_bad = 0;
        for (int i = 0; i < WIN; i++) begin
            iBit   = bit_of(mode, i);
            iStart = (i == WIN - 1) && hold_start;
            tick();
            if (oValid) begin
                vcnt++;
                vpos = i;
            end
            if (i < WIN - 1 && !oBusy) busy_bad++;
            if (i == WIN - 1 && oBusy != hold_start) busy_bad++;
        end
        iStart = 1'b0;
        iBit   = 1'b0;
    endtask

    int vcnt, vpos, busy_bad;
    int seen;

    initial begin
        rst = 1'b1; iStart = 1'b0; iClr = 1'b0; iBit = 1'b0;
        #12;
        check("rst_busy", oBusy, 0);
        check("rst_valid", oValid, 0);
        check("rst_data", oData, 0);
        check("rst_sat", oSat, 0);
        rst = 1'b0;
        tick();

        // iBit ignored while idle
        iBit = 1'b1;
        repeat (3) tick();
        check("idle_busy", oBusy, 0);
        check("idle_valid", oValid, 0);

        // Zero stream: valid lands after the 256th RUN cycle
        do_start();
        check("zero_busy_t1", oBusy, 1);
        run_window(M_ZERO, 1'b0, vcnt, vpos, busy_bad);
        check("zero_vcnt", vcnt, 1);
        check("zero_vpos", vpos, WIN - 1);
        check("zero_busy", busy_bad, 0);
        check("zero_data", oData, 0);
        check("zero_sat", oSat, 0);
        tick();
        check("zero_pulse_1cyc", oValid, 0);

        // All ones saturates
        do_start();
        run_window(M_ONES, 1'b0, vcnt, vpos, busy_bad);
        check("ones_vpos", vpos, WIN - 1);
        check("ones_data", oData, 255);
        check("ones_sat", oSat, 1);
        tick();

        // Alternating 1,0
        do_start();
        run_window(M_ALT, 1'b0, vcnt, vpos, busy_bad);
        check("alt_vcnt", vcnt, 1);
        check("alt_data", oData, 128);
        check("alt_sat", oSat, 0);
        tick();

        // Abort at sample 100: no valid, outputs retained
        do_start();
        for (int i = 0; i < 100; i++) begin
            iBit = 1'b1;
            tick();
        end
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        check("clr_busy", oBusy, 0);
        check("clr_valid", oValid, 0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (oValid) seen++;
        end
        check("clr_no_valid", seen, 0);
        check("clr_data_kept", oData, 128);
        check("clr_sat_kept", oSat, 0);

        // iClr wins over iStart in idle
        iClr = 1'b1; iStart = 1'b1;
        tick();
        iClr = 1'b0; iStart = 1'b0;
        check("clr_over_start", oBusy, 0);

        // 3-of-8 pattern after the abort
        do_start();
        run_window(M_P3, 1'b0, vcnt, vpos, busy_bad);
        check("p3_vcnt", vcnt, 1);
        check("p3_data", oData, 96);
        check("p3_sat", oSat, 0);
        tick();

        // Back-to-back: start held on the final cycle, no gap
        do_start();
        run_window(M_ONES, 1'b1, vcnt, vpos, busy_bad);
        check("b2b1_vpos", vpos, WIN - 1);
        check("b2b1_busy", busy_bad, 0);
        check("b2b1_data", oData, 255);
        check("b2b1_sat", oSat, 1);
        run_window(M_64, 1'b0, vcnt, vpos, busy_bad);
        check("b2b2_vcnt", vcnt, 1);
        check("b2b2_vpos", vpos, WIN - 1);
        check("b2b2_busy", busy_bad, 0);
        check("b2b2_data", oData, 64);
        check("b2b2_sat", oSat, 0);
        tick();
        check("b2b_idle", oBusy, 0);

        // Async reset mid-window, between edges
        do_start();
        for (int i = 0; i < 50; i++) begin
            iBit = 1'b1;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        check("arst_busy", oBusy, 0);
        check("arst_valid", oValid, 0);
        check("arst_data", oData, 0);
        check("arst_sat", oSat, 0);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (oValid) seen++;
        end
        check("arst_no_valid", seen, 0);
        do_start();
        run_window(M_ALT, 1'b0, vcnt, vpos, busy_bad);
        check("arst_win_vpos", vpos, WIN - 1);
        check("arst_win_data", oData, 128);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
